// File: rtl/jkff_bank.sv
// Bank of independent falling-edge flip-flops, each bit acting as JK, D, T or SR
// according to a shared mode, with a sticky illegal-SR flag and a saturating bit-change counter.
module jkff_bank #(
    parameter int unsigned         WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam int unsigned POP_W = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic             w_illegal;
    logic [WIDTH-1:0] w_diff;
    logic [POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    // Per-bit next state; an S=R=1 bit holds and only raises the illegal flag.
    always_comb begin
        w_q_next  = r_q;
        w_illegal = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_JK: begin
                    case ({j[i], k[i]})
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b11:   w_q_next[i] = ~r_q[i];
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
                MODE_D:  w_q_next[i] = j[i];
                MODE_T:  w_q_next[i] = r_q[i] ^ j[i];
                default: begin
                    case ({j[i], k[i]})
                        2'b01:   w_q_next[i] = 1'b0;
                        2'b10:   w_q_next[i] = 1'b1;
                        2'b11: begin
                            w_q_next[i] = r_q[i];
                            w_illegal   = 1'b1;
                        end
                        default: w_q_next[i] = r_q[i];
                    endcase
                end
            endcase
        end
    end

    // Count of bits that change on this edge, added with saturation.
    always_comb begin
        w_diff = r_q ^ w_q_next;
        w_pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + POP_W'(w_diff[i]);
        end
        w_sum      = {1'b0, r_cnt} + (CNT_W + 1)'(w_pop);
        w_cnt_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= RESET_VAL;
            r_qbar <= ~RESET_VAL;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (en) begin
                r_q    <= w_q_next;
                r_qbar <= ~w_q_next;
                r_cnt  <= w_cnt_next;
            end
            // Setting by an illegal SR edge takes priority over clearing.
            if (en && w_illegal) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign q       = r_q;
    assign qbar    = r_qbar;
    assign err     = r_err;
    assign chg_cnt = r_cnt;

endmodule

// File: tb/tb_jkff_bank.sv
// Bench for jkff_bank (WIDTH=4, CNT_W=4): directed literal checks plus a
// behavioural model compared on every rising edge, between the falling active edges.
module tb_jkff_bank;

    localparam logic [1:0] JK = 2'b00;
    localparam logic [1:0] DM = 2'b01;
    localparam logic [1:0] TM = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       err_clr;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       err;
    logic [3:0] chg_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    logic [3:0] m_q   = 4'b0000;
    logic       m_err = 1'b0;
    int         m_cnt = 0;

    jkff_bank #(
        .WIDTH     (4),
        .RESET_VAL (4'b0000),
        .CNT_W     (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .err_clr (err_clr),
        .q       (q),
        .qbar    (qbar),
        .err     (err),
        .chg_cnt (chg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: each bit from its truth table, counter as a clamped integer sum.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   = 4'b0000;
            m_err = 1'b0;
            m_cnt = 0;
        end else if (en) begin
            logic [3:0] nq;
            logic       bad;
            int         changes;
            bad     = 1'b0;
            changes = 0;
            for (int i = 0; i < 4; i++) begin
                logic a, b, cur, nb;
                a   = j[i];
                b   = k[i];
                cur = m_q[i];
                nb  = cur;
                if (mode == DM)      nb = a;
                else if (mode == TM) nb = a ? !cur : cur;
                else if (mode == JK) begin
                    if (a && b)  nb = !cur;
                    else if (a)  nb = 1'b1;
                    else if (b)  nb = 1'b0;
                end else begin
                    if (a && b)  bad = 1'b1;
                    else if (a)  nb = 1'b1;
                    else if (b)  nb = 1'b0;
                end
                nq[i] = nb;
                if (nb != cur) changes++;
            end
            m_q   = nq;
            m_cnt = (m_cnt + changes > 15) ? 15 : m_cnt + changes;
            if (bad)          m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end else if (err_clr) begin
            m_err = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            check("model_q", 32'(q), 32'(m_q));
            check("model_qbar", 32'(qbar), 32'(4'(~m_q)));
            check("model_err", 32'(err), 32'(m_err));
            check("model_cnt", 32'(chg_cnt), 32'(m_cnt));
        end
    end

    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] jj,
                        input logic [3:0] kk, input logic ec);
        en = e; mode = m; j = jj; k = kk; err_clr = ec;
        @(negedge clk);
        #1;
    endtask

    task automatic exp_lit(input string tag, input logic [3:0] eq, input logic ee, input int ec);
        check({tag, "_q"}, 32'(q), 32'(eq));
        check({tag, "_qbar"}, 32'(qbar), 32'(4'(~eq)));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_cnt"}, 32'(chg_cnt), 32'(ec));
    endtask

    initial begin
        logic [3:0] t_q   [5];
        int         t_cnt [5];
        t_q   = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
        t_cnt = '{4, 8, 12, 15, 15};

        rst_n = 1'b0; en = 1'b0; mode = JK; j = '0; k = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        exp_lit("reset", 4'b0000, 1'b0, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        step(1'b1, JK, 4'b1010, 4'b0101, 1'b0); exp_lit("jk_set",    4'b1010, 1'b0, 2);
        step(1'b1, JK, 4'b1111, 4'b1111, 1'b0); exp_lit("jk_toggle", 4'b0101, 1'b0, 6);
        step(1'b1, DM, 4'b1111, 4'b0000, 1'b0); exp_lit("d_load",    4'b1111, 1'b0, 8);
        step(1'b1, TM, 4'b0011, 4'b1111, 1'b0); exp_lit("t_flip",    4'b1100, 1'b0, 10);
        step(1'b0, DM, 4'b0000, 4'b1111, 1'b0); exp_lit("en_hold",   4'b1100, 1'b0, 10);
        step(1'b1, SR, 4'b1001, 4'b1100, 1'b0); exp_lit("sr_mixed",  4'b1001, 1'b1, 12);

        // Asynchronous reset between edges, then a clock edge while still held.
        #2; rst_n = 1'b0; #1;
        exp_lit("async_rst", 4'b0000, 1'b0, 0);
        step(1'b1, TM, 4'b1111, 4'b0000, 1'b0); exp_lit("rst_held",  4'b0000, 1'b0, 0);
        rst_n = 1'b1;

        step(1'b1, SR, 4'b1001, 4'b1100, 1'b0); exp_lit("sr_illegal", 4'b0001, 1'b1, 1);
        step(1'b1, SR, 4'b0000, 4'b0000, 1'b1); exp_lit("err_clr",    4'b0001, 1'b0, 1);
        step(1'b1, SR, 4'b0001, 4'b0001, 1'b1); exp_lit("set_wins",   4'b0001, 1'b1, 1);
        step(1'b0, SR, 4'b1111, 4'b1111, 1'b1); exp_lit("dis_clr",    4'b0001, 1'b0, 1);
        step(1'b0, SR, 4'b1111, 4'b1111, 1'b0); exp_lit("dis_noset",  4'b0001, 1'b0, 1);

        #2; rst_n = 1'b0; #1; rst_n = 1'b1;
        exp_lit("rst_pulse", 4'b0000, 1'b0, 0);
        for (int n = 0; n < 5; n++) begin
            step(1'b1, TM, 4'b1111, 4'b0000, 1'b0);
            exp_lit($sformatf("sat%0d", n), t_q[n], 1'b0, t_cnt[n]);
        end

        for (int n = 0; n < 1000; n++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0);
        end
        rst_n = 1'b1;
        step(1'b0, JK, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
